// File: rtl/jtag_pkg.sv
// Shared types and helpers for the JTAG TDO transmitter.
// JTAG_TX_PARITY_EN appends an odd-parity bit, so each transfer is one bit longer.
package jtag_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } tx_state_t;

  localparam logic TDO_IDLE = 1'b0;

  function automatic int nbits(input int width);
`ifdef JTAG_TX_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/tdo_retimer.sv
// Falling-edge TDO launch flop; the only negedge flop in the transmitter.
module tdo_retimer
  import jtag_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic tx_bit,
  output logic tdo
);

  always_ff @(negedge clk) begin
    if (reset) tdo <= TDO_IDLE;
    else       tdo <= tx_bit;
  end

endmodule

// File: rtl/jtag_shift_transmitter.sv
// Parametrised JTAG TDO serialiser: valid/ready load, pausable/abortable shift-out.
// Build option JTAG_TX_PARITY_EN appends odd parity over the loaded word as the last bit.
module jtag_shift_transmitter
  import jtag_pkg::*;
#(
  parameter  int WIDTH     = 32,
  parameter  int LSB_FIRST = 0,
  localparam int NBITS     = nbits(WIDTH),
  localparam int BLW       = $clog2(NBITS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             abort,
  output logic             tdo,
  output logic             busy,
  output logic             done,
  output logic [BLW-1:0]   bits_left
);

  tx_state_t        r_state, w_state_nxt;
  logic [NBITS-1:0] r_sreg, w_sreg_nxt, w_load_word, w_shifted;
  logic             r_tx_bit, w_tx_bit_nxt, w_head_bit;
  logic [BLW-1:0]   r_bits_left, w_bits_left_nxt;

  // Parity sits at the end that leaves the register last.
  always_comb begin
`ifdef JTAG_TX_PARITY_EN
    if (LSB_FIRST != 0) w_load_word = {~^load_data, load_data};
    else                w_load_word = {load_data, ~^load_data};
`else
    w_load_word = load_data;
`endif
  end

  always_comb begin
    if (LSB_FIRST != 0) begin
      w_head_bit = r_sreg[0];
      w_shifted  = {1'b0, r_sreg[NBITS-1:1]};
    end else begin
      w_head_bit = r_sreg[NBITS-1];
      w_shifted  = {r_sreg[NBITS-2:0], 1'b0};
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_sreg_nxt      = r_sreg;
    w_tx_bit_nxt    = r_tx_bit;
    w_bits_left_nxt = r_bits_left;
    if (abort) begin
      w_state_nxt     = IDLE;
      w_tx_bit_nxt    = TDO_IDLE;
      w_bits_left_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (load_valid) begin
            w_sreg_nxt      = w_load_word;
            w_bits_left_nxt = BLW'(NBITS);
            w_state_nxt     = SHIFT;
          end
        end
        SHIFT: begin
          if (shift_en) begin
            w_tx_bit_nxt    = w_head_bit;
            w_sreg_nxt      = w_shifted;
            w_bits_left_nxt = r_bits_left - 1'b1;
            if (r_bits_left == BLW'(1)) w_state_nxt = DONE;
          end
        end
        DONE: begin
          w_tx_bit_nxt = TDO_IDLE;
          if (!shift_en) w_state_nxt = IDLE;
        end
        default: begin
          w_state_nxt  = IDLE;
          w_tx_bit_nxt = TDO_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_tx_bit    <= TDO_IDLE;
      r_bits_left <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_tx_bit    <= w_tx_bit_nxt;
      r_bits_left <= w_bits_left_nxt;
    end
  end

  // Payload register carries no reset; the control path alone defines validity.
  always_ff @(posedge clk) begin
    r_sreg <= w_sreg_nxt;
  end

  assign load_ready = (r_state == IDLE);
  assign busy       = (r_state == SHIFT);
  assign done       = (r_state == DONE);
  assign bits_left  = r_bits_left;

  tdo_retimer u_tdo_retimer (
    .clk    (clk),
    .reset  (reset),
    .tx_bit (r_tx_bit),
    .tdo    (tdo)
  );

endmodule

// File: tb/tb_jtag_shift_transmitter.sv
// Bench for jtag_shift_transmitter: MSB-first and LSB-first instances share one stimulus.
module tb_jtag_shift_transmitter;

  localparam int W = 32;
`ifdef JTAG_TX_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif
  localparam int BLW = $clog2(NB + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, load_valid, shift_en, abort;
  logic [W-1:0]  load_data;
  logic          lr_m, busy_m, done_m, tdo_m;
  logic          lr_l, busy_l, done_l, tdo_l;
  logic [BLW-1:0] bl_m, bl_l;

  jtag_shift_transmitter #(.WIDTH(W), .LSB_FIRST(0)) dut_m (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(lr_m),
    .load_data(load_data), .shift_en(shift_en), .abort(abort), .tdo(tdo_m),
    .busy(busy_m), .done(done_m), .bits_left(bl_m)
  );

  jtag_shift_transmitter #(.WIDTH(W), .LSB_FIRST(1)) dut_l (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(lr_l),
    .load_data(load_data), .shift_en(shift_en), .abort(abort), .tdo(tdo_l),
    .busy(busy_l), .done(done_l), .bits_left(bl_l)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference model: phase 0=idle 1=shifting 2=finished; bit k of a transfer is
  // taken straight from the captured word by index.
  int         mst = 0;
  int         mbl = 0;
  bit         mtx[2] = '{1'b0, 1'b0};
  logic [W-1:0] mword = '0;

  function automatic bit ebit(input bit lsb, input int k);
    if (k < W) return lsb ? mword[k] : mword[W-1-k];
    return ~^mword;
  endfunction

  task automatic model(input bit r, input bit ab, input bit lv, input bit se, input logic [W-1:0] d);
    if (r || ab) begin
      mst = 0; mbl = 0; mtx[0] = 1'b0; mtx[1] = 1'b0;
    end else if (mst == 0) begin
      if (lv) begin mword = d; mbl = NB; mst = 1; end
    end else if (mst == 1) begin
      if (se) begin
        mtx[0] = ebit(1'b0, NB - mbl);
        mtx[1] = ebit(1'b1, NB - mbl);
        mbl--;
        if (mbl == 0) mst = 2;
      end
    end else begin
      mtx[0] = 1'b0; mtx[1] = 1'b0;
      if (!se) mst = 0;
    end
  endtask

  typedef struct {
    bit rst, ab, lv, se;
    logic [W-1:0] d;
    bit lr, bz, dn;
    int bl;
    bit tm, tl;
  } vec_t;

  vec_t tbl[14];

  task automatic run(input bit r, input bit ab, input bit lv, input bit se,
                     input logic [W-1:0] d, input int ti);
    reset = r; abort = ab; load_valid = lv; shift_en = se; load_data = d;
    @(posedge clk);
    model(r, ab, lv, se, d);
    #1;
    if (ti >= 0) begin
      chk($sformatf("tbl%0d load_ready_m", ti), lr_m,   tbl[ti].lr);
      chk($sformatf("tbl%0d load_ready_l", ti), lr_l,   tbl[ti].lr);
      chk($sformatf("tbl%0d busy", ti),         busy_m, tbl[ti].bz);
      chk($sformatf("tbl%0d done", ti),         done_m, tbl[ti].dn);
      chk($sformatf("tbl%0d bits_left_m", ti),  bl_m,   tbl[ti].bl);
      chk($sformatf("tbl%0d bits_left_l", ti),  bl_l,   tbl[ti].bl);
    end else begin
      chk("load_ready_m", lr_m,   mst == 0);
      chk("load_ready_l", lr_l,   mst == 0);
      chk("busy_m",       busy_m, mst == 1);
      chk("busy_l",       busy_l, mst == 1);
      chk("done_m",       done_m, mst == 2);
      chk("done_l",       done_l, mst == 2);
      chk("bits_left_m",  bl_m,   mbl);
      chk("bits_left_l",  bl_l,   mbl);
    end
    @(negedge clk);
    #1;
    if (ti >= 0) begin
      chk($sformatf("tbl%0d tdo_m", ti), tdo_m, tbl[ti].tm);
      chk($sformatf("tbl%0d tdo_l", ti), tdo_l, tbl[ti].tl);
    end else begin
      chk("tdo_m", tdo_m, mtx[0]);
      chk("tdo_l", tdo_l, mtx[1]);
    end
  endtask

  initial begin
    logic [W-1:0] w;
    // 0xDEADBEEF: MSB-first 1,1,0,1,1,1,1,0  LSB-first 1,1,1,1,0,1,1,1
    tbl[0]  = '{1,0,0,0,32'h0,        1,0,0,0,      0,0};
    tbl[1]  = '{1,0,1,1,32'hDEADBEEF, 1,0,0,0,      0,0};
    tbl[2]  = '{0,0,1,1,32'hDEADBEEF, 0,1,0,NB,     0,0};
    tbl[3]  = '{0,0,1,1,32'h0,        0,1,0,NB-1,   1,1};
    tbl[4]  = '{0,0,0,1,32'h0,        0,1,0,NB-2,   1,1};
    tbl[5]  = '{0,0,0,1,32'h0,        0,1,0,NB-3,   0,1};
    tbl[6]  = '{0,0,0,1,32'h0,        0,1,0,NB-4,   1,1};
    tbl[7]  = '{0,0,0,1,32'h0,        0,1,0,NB-5,   1,0};
    tbl[8]  = '{0,0,1,0,32'h0,        0,1,0,NB-5,   1,0};
    tbl[9]  = '{0,0,0,0,32'h0,        0,1,0,NB-5,   1,0};
    tbl[10] = '{0,0,0,0,32'h0,        0,1,0,NB-5,   1,0};
    tbl[11] = '{0,0,0,1,32'h0,        0,1,0,NB-6,   1,1};
    tbl[12] = '{0,0,0,1,32'h0,        0,1,0,NB-7,   1,1};
    tbl[13] = '{0,0,0,1,32'h0,        0,1,0,NB-8,   0,1};

    for (int i = 0; i < 14; i++)
      run(tbl[i].rst, tbl[i].ab, tbl[i].lv, tbl[i].se, tbl[i].d, i);

    // Finish the 0xDEADBEEF transfer, then watch TDO drop and DONE release.
    for (int i = 0; i < NB - 8; i++) run(0, 0, 0, 1, '0, -1);
    chk("final done", done_m, 1'b1);
    chk("final bits_left", bl_m, 0);
    run(0, 0, 1, 1, '0, -1);
    chk("done held tdo", tdo_m, 1'b0);
    run(0, 0, 0, 0, '0, -1);
    chk("back to idle", lr_m, 1'b1);

    // Single-bit word: only the LSB-first instance leads with a 1.
    run(0, 0, 1, 0, 32'h1, -1);
    run(0, 0, 0, 1, '0, -1);
    chk("lsb first bit", tdo_l, 1'b1);
    chk("msb first bit", tdo_m, 1'b0);
    for (int i = 1; i < NB; i++) run(0, 0, 0, 1, '0, -1);
    run(0, 0, 0, 0, '0, -1);

    // Abort after 10 bits (with a competing load), then reload immediately.
    run(0, 0, 1, 0, $urandom, -1);
    for (int i = 0; i < 10; i++) run(0, 0, 0, 1, '0, -1);
    run(0, 1, 1, 1, 32'hFFFFFFFF, -1);
    chk("abort idle", lr_m, 1'b1);
    chk("abort tdo", tdo_m, 1'b0);
    w = $urandom;
    run(0, 0, 1, 0, w, -1);
    chk("reload busy", busy_m, 1'b1);
    for (int i = 0; i < 7; i++) run(0, 0, 0, 1, '0, -1);

    // Reset mid-shift.
    run(1, 0, 1, 1, '0, -1);
    chk("reset bits_left", bl_m, 0);
    run(0, 0, 0, 0, '0, -1);

    for (int i = 0; i < 4000; i++)
      run(($urandom % 200) == 0, ($urandom % 80) == 0, ($urandom % 4) == 0,
          ($urandom % 5) != 0, $urandom, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_shift_transmitter.md
# jtag_shift_transmitter

Parametrised JTAG TDO serialiser. It captures a WIDTH-bit data register through a valid/ready load handshake, then shifts it out one bit per enabled clock, MSB- or LSB-first. Shifting can pause and can be aborted. The block sits between the TAP controller (which drives `shift_en` during Shift-DR/Shift-IR) and the TDO pad, and replaces the fixed 32-bit transmitter.

## Interface
- `WIDTH`, 32: bits per transfer; legal range 2..64.
- `LSB_FIRST`, 0: 0 = MSB shifted first, 1 = LSB shifted first.
- `clk` input 1: TCK-domain clock.
- `reset` input 1: reset, synchronous, active-high; applies to both posedge and negedge flops.
- `load_valid` input 1: `load_data` is valid.
- `load_ready` output 1: the block accepts a load; high only in IDLE.
- `load_data` input WIDTH: word to transmit; captured on handshake.
- `shift_en` input 1: TAP is in a shift state; each high posedge advances one bit.
- `abort` input 1: drop the current transfer and return to IDLE.
- `tdo` output 1: serial data, updated on the falling edge.
- `busy` output 1: state is SHIFT.
- `done` output 1: last bit presented; held until `shift_en` falls.
- `bits_left` output `$clog2(NBITS+1)`: bits remaining to present.

## Operation
- NBITS = WIDTH, plus 1 when parity is compiled in.
- State machine (posedge):
  - IDLE: `load_ready`=1. On `load_valid`: capture `load_data` into the shift register, set `bits_left`=NBITS, go to SHIFT.
  - SHIFT: each posedge with `shift_en`=1 moves the next bit into `tx_bit`, shifts the register and decrements `bits_left`. The edge that moves the final bit (`bits_left` 1→0) also goes to DONE. With `shift_en`=0 all state holds (pause).
  - DONE: `done`=1 and `tx_bit`=0. When `shift_en`=0, go to IDLE.
- Bit order: `LSB_FIRST`=0 presents `load_data[WIDTH-1]` first, `LSB_FIRST`=1 presents `load_data[0]` first. The parity bit, when present, is always last.
- `tdo` is a negedge flop loaded from `tx_bit`, so data launches half a cycle before the TAP samples it (hold margin).
- Priority: `reset` > `abort` > load/shift.
  - `abort` in any state: go to IDLE, `tx_bit`=0, `bits_left`=0, `done`=0.
  - `load_valid` outside IDLE is ignored.
  - `shift_en` in IDLE has no effect and `tdo` stays 0.
- Reset values: IDLE, `load_ready`=1, `busy`=0, `done`=0, `bits_left`=0, `tx_bit`=0, `tdo`=0 (at the next negedge with `reset` high).

## Timing
- Load at posedge N. The first `shift_en` posedge M ≥ N+1 puts bit 0 on `tx_bit`, and `tdo` shows it after negedge M.
- A load and a shift cannot coincide. A `shift_en` high at the load edge is ignored.
- `done` rises on the same posedge that presents the final bit. `tdo` carries that final bit from the following negedge for one enabled cycle, then 0.
- `busy` and `load_ready` are registered and change only on posedge.
- Back-to-back transfers: DONE→IDLE needs one `shift_en`-low edge, and the next load is accepted on the edge after that.

## Configuration
- `JTAG_TX_PARITY_EN` defined:
  - Odd parity over the captured word is computed at load (`~^load_data`) and shifted as bit NBITS after the data.
  - NBITS = WIDTH+1.
- Undefined: no parity logic; NBITS = WIDTH.

## Structure
- The shared package `jtag_pkg` holds:
  - the state enum `tx_state_t` (IDLE, SHIFT, DONE);
  - the function `nbits(width)`;
  - a localparam for the TDO idle level (0).
- Sub-module `tdo_retimer`: negedge flop with synchronous reset, input `tx_bit`, output `tdo`. It keeps the single negedge domain isolated for STA.

## Test plan
- WIDTH=32, `LSB_FIRST`=0, load 0xDEADBEEF, `shift_en` held high → `tdo` bits 1,1,0,1,1,1,1,0,… (32 bits); `done`=1 on the 32nd shift edge; `bits_left`=0; then `tdo`=0.
- `LSB_FIRST`=1, load 0x00000001 → first `tdo` bit 1, the remaining 31 bits 0; `done` after 32 edges.
- Pause: drop `shift_en` after 5 bits for 3 cycles → `bits_left` holds at 27 and `tdo` holds; resume completes after 27 more edges.
- Abort after 10 bits → next posedge gives IDLE, `load_ready`=1, `busy`=0; `tdo`=0 at the next negedge; a new load is accepted immediately.
- `JTAG_TX_PARITY_EN`, WIDTH=8, load 0x07 → `tdo` 0,0,0,0,0,1,1,1, then parity 0; `done` on the 9th edge.
- Reset asserted mid-shift, and `load_valid` asserted while busy → all outputs take their reset values; the ignored load does not corrupt the word in flight.
